ao_tree_pipe: RTL and testbench

AO_TREE_PIPE -- requirements
Module: ao_tree_pipe

---
 rtl/ao_pkg.sv | 9 +
 rtl/ao_pipe_stage.sv | 31 +++
 rtl/ao_tree_pipe.sv | 98 +++++++++
 tb/tb_ao_tree_pipe.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ao_pkg.sv
// Shared limits and output-mode constants for the AND-OR tree pipeline.
package ao_pkg;

  localparam int unsigned NPROD_MAX   = 16;
  localparam int unsigned WIDTH_MAX   = 64;
  localparam int unsigned AO_MODE_AO  = 0;
  localparam int unsigned AO_MODE_AOI = 1;

endpackage

// File: rtl/ao_pipe_stage.sv
// Valid/ready register slice of parametrised width; loads when empty or draining.
module ao_pipe_stage #(
  parameter int unsigned W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  // Bubble collapse: an empty slot accepts even while downstream stalls.
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= RST_VAL;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/ao_tree_pipe.sv
// Two-stage pipelined AND-OR / AND-OR-INVERT tree with valid/ready handshake.
// Optional per-product enable port when AO_TREE_PIPE_MASK_EN is defined.
module ao_tree_pipe
  import ao_pkg::*;
#(
  parameter int unsigned NPROD  = 2,
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned INVERT = AO_MODE_AO
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [NPROD*WIDTH-1:0] IN_A,
  input  logic [NPROD*WIDTH-1:0] IN_B,
`ifdef AO_TREE_PIPE_MASK_EN
  input  logic [NPROD-1:0]       PROD_EN,
`endif
  input  logic                   IN_VALID,
  output logic                   IN_READY,
  output logic [WIDTH-1:0]       Q,
  output logic                   Q_VALID,
  input  logic                   Q_READY
);

  localparam int unsigned PW = NPROD * WIDTH;
  localparam logic [WIDTH-1:0] Q_RST = (INVERT == AO_MODE_AOI) ? '1 : '0;

  if (NPROD < 2 || NPROD > NPROD_MAX) begin : g_bad_nprod
    $error("ao_tree_pipe: NPROD must be 2..16");
  end
  if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("ao_tree_pipe: WIDTH must be 1..64");
  end
  if (INVERT != AO_MODE_AO && INVERT != AO_MODE_AOI) begin : g_bad_invert
    $error("ao_tree_pipe: INVERT must be 0 or 1");
  end

  logic [NPROD-1:0] prod_en;
`ifdef AO_TREE_PIPE_MASK_EN
  assign prod_en = PROD_EN;
`else
  assign prod_en = '1;
`endif

  logic [PW-1:0]    prod;
  logic [PW-1:0]    s1_prod;
  logic             s1_valid;
  logic             s2_ready;
  logic [WIDTH-1:0] or_tree;
  logic [WIDTH-1:0] s2_in;

  // Per-product AND terms, masked by the product enable.
  always_comb begin
    prod = '0;
    for (int unsigned k = 0; k < NPROD; k++) begin
      prod[k*WIDTH +: WIDTH] = IN_A[k*WIDTH +: WIDTH] & IN_B[k*WIDTH +: WIDTH]
                               & {WIDTH{prod_en[k]}};
    end
  end

  ao_pipe_stage #(
    .W       (PW),
    .RST_VAL ('0)
  ) u_stage1 (
    .clk       (CLK),
    .rst       (RST),
    .in_data   (prod),
    .in_valid  (IN_VALID),
    .in_ready  (IN_READY),
    .out_data  (s1_prod),
    .out_valid (s1_valid),
    .out_ready (s2_ready)
  );

  // OR across registered products; inversion folded in before stage 2.
  always_comb begin
    or_tree = '0;
    for (int unsigned k = 0; k < NPROD; k++) begin
      or_tree = or_tree | s1_prod[k*WIDTH +: WIDTH];
    end
  end

  assign s2_in = (INVERT == AO_MODE_AOI) ? ~or_tree : or_tree;

  ao_pipe_stage #(
    .W       (WIDTH),
    .RST_VAL (Q_RST)
  ) u_stage2 (
    .clk       (CLK),
    .rst       (RST),
    .in_data   (s2_in),
    .in_valid  (s1_valid),
    .in_ready  (s2_ready),
    .out_data  (Q),
    .out_valid (Q_VALID),
    .out_ready (Q_READY)
  );

endmodule

// File: tb/tb_ao_tree_pipe.sv
// Bench for ao_tree_pipe: AO22 truth table, AOI4x8 vectors, stall/reset sequences, random stream.
module tb_ao_tree_pipe;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- instance A: AO22, WIDTH=1 ----------------
  logic       rst_a = 1'b1;
  logic [1:0] a_a = '0, b_a = '0;
  logic       in_valid_a = 1'b0, q_ready_a = 1'b1;
  logic       in_ready_a, q_a, q_valid_a;

  ao_tree_pipe #(.NPROD(2), .WIDTH(1), .INVERT(0)) u_ao22 (
    .CLK(CLK), .RST(rst_a), .IN_A(a_a), .IN_B(b_a),
`ifdef AO_TREE_PIPE_MASK_EN
    .PROD_EN(2'b11),
`endif
    .IN_VALID(in_valid_a), .IN_READY(in_ready_a),
    .Q(q_a), .Q_VALID(q_valid_a), .Q_READY(q_ready_a)
  );

  // ---------------- instance B: AOI, 4 products x 8 bits ----------------
  logic        rst_b = 1'b1;
  logic [31:0] a_b = '0, b_b = '0;
  logic [3:0]  en_b = '1;
  logic        in_valid_b = 1'b0, q_ready_b = 1'b1;
  logic        in_ready_b, q_valid_b;
  logic [7:0]  q_b;

  ao_tree_pipe #(.NPROD(4), .WIDTH(8), .INVERT(1)) u_aoi (
    .CLK(CLK), .RST(rst_b), .IN_A(a_b), .IN_B(b_b),
`ifdef AO_TREE_PIPE_MASK_EN
    .PROD_EN(en_b),
`endif
    .IN_VALID(in_valid_b), .IN_READY(in_ready_b),
    .Q(q_b), .Q_VALID(q_valid_b), .Q_READY(q_ready_b)
  );

`ifdef AO_TREE_PIPE_MASK_EN
  logic       rst_c = 1'b1;
  logic [7:0] a_c = '0, b_c = '0;
  logic [1:0] en_c = '0;
  logic       in_valid_c = 1'b0, in_ready_c, q_valid_c;
  logic [3:0] q_c;

  ao_tree_pipe #(.NPROD(2), .WIDTH(4), .INVERT(0)) u_mask (
    .CLK(CLK), .RST(rst_c), .IN_A(a_c), .IN_B(b_c), .PROD_EN(en_c),
    .IN_VALID(in_valid_c), .IN_READY(in_ready_c),
    .Q(q_c), .Q_VALID(q_valid_c), .Q_READY(1'b1)
  );
`endif

  // Reference for instance B: AND each enabled slice pair, OR them, invert.
  function automatic logic [7:0] model_b(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] en);
    logic [7:0] r;
    r = 8'h00;
    for (int k = 0; k < 4; k++) begin
      if (en[k]) r = r | (a[k*8 +: 8] & b[k*8 +: 8]);
    end
    return ~r;
  endfunction

  typedef struct {
    logic [7:0] q;
    int         t;
  } sb_t;

  sb_t        sb[$];
  int         cyc = 0;
  int         n_pop = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_q = '0;
  logic       saw_block = 1'b0;

  // One clock of instance B: drive, check against the queue model, record transfers.
  task automatic step_b(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] en, input logic qr, input logic rst,
                        input logic use_exp, input logic [7:0] exp_q, output logic acc);
    logic [3:0] en_eff;
    logic [7:0] e;
    sb_t        item;
    @(negedge CLK);
    rst_b = rst; in_valid_b = v; a_b = a; b_b = b; en_b = en; q_ready_b = qr;
    #1;
    acc = 1'b0;
    if (rst) begin
      sb.delete();
      prev_stall = 1'b0;
    end else begin
      check("b_in_ready", 64'(in_ready_b), 64'((sb.size() < 2) || qr));
      check("b_q_valid", 64'(q_valid_b), 64'(sb.size() > 0 && (cyc - sb[0].t) >= 2));
      if (q_valid_b && sb.size() > 0) check("b_q_data", 64'(q_b), 64'(sb[0].q));
      if (prev_stall) check("b_q_stable", 64'(q_b), 64'(prev_q));
      if (!in_ready_b) saw_block = 1'b1;
      if (q_valid_b && qr && sb.size() > 0) begin
        void'(sb.pop_front());
        n_pop++;
      end
      if (v && in_ready_b) begin
        en_eff = en;
`ifndef AO_TREE_PIPE_MASK_EN
        en_eff = 4'hF;
`endif
        e = use_exp ? exp_q : model_b(a, b, en_eff);
        item.q = e;
        item.t = cyc;
        sb.push_back(item);
        acc = 1'b1;
      end
      prev_stall = q_valid_b && !qr;
      prev_q     = q_b;
    end
    cyc++;
  endtask

  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
    logic       q;
  } vec_a_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  q;
  } vec_b_t;

  vec_a_t tab_a[16];
  vec_b_t tab_b[6];
  logic [31:0] seq_a[10], seq_b[10];

  initial begin
    logic acc;
    int   sent;
    int   pops0;

    // AO22 truth table: Q = a1&b1 | a0&b0.
    tab_a[0]  = '{2'b00, 2'b00, 1'b0}; tab_a[1]  = '{2'b00, 2'b01, 1'b0};
    tab_a[2]  = '{2'b00, 2'b10, 1'b0}; tab_a[3]  = '{2'b00, 2'b11, 1'b0};
    tab_a[4]  = '{2'b01, 2'b00, 1'b0}; tab_a[5]  = '{2'b01, 2'b01, 1'b1};
    tab_a[6]  = '{2'b01, 2'b10, 1'b0}; tab_a[7]  = '{2'b01, 2'b11, 1'b1};
    tab_a[8]  = '{2'b10, 2'b00, 1'b0}; tab_a[9]  = '{2'b10, 2'b01, 1'b0};
    tab_a[10] = '{2'b10, 2'b10, 1'b1}; tab_a[11] = '{2'b10, 2'b11, 1'b1};
    tab_a[12] = '{2'b11, 2'b00, 1'b0}; tab_a[13] = '{2'b11, 2'b01, 1'b1};
    tab_a[14] = '{2'b11, 2'b10, 1'b1}; tab_a[15] = '{2'b11, 2'b11, 1'b1};

    tab_b[0] = '{32'h0000_0000, 32'h0000_0000, 8'hFF};
    tab_b[1] = '{32'h0000_000F, 32'h0000_000F, 8'hF0};
    tab_b[2] = '{32'hFFFF_FFFF, 32'h0000_0000, 8'hFF};
    tab_b[3] = '{32'hFF00_0000, 32'h0F00_0000, 8'hF0};
    tab_b[4] = '{32'h8040_2010, 32'hFFFF_FFFF, 8'h0F};
    tab_b[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'h00};

    for (int i = 0; i < 10; i++) begin
      seq_a[i] = $urandom;
      seq_b[i] = $urandom;
    end

    // Reset state of both instances.
    repeat (2) @(negedge CLK);
    #1;
    check("a_rst_q_valid", 64'(q_valid_a), 64'd0);
    check("a_rst_in_ready", 64'(in_ready_a), 64'd1);
    check("a_rst_q", 64'(q_a), 64'd0);
    check("b_rst_q_valid", 64'(q_valid_b), 64'd0);
    check("b_rst_q", 64'(q_b), 64'hFF);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // AO22 sweep: each vector appears exactly two edges after its transfer.
    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      in_valid_a = 1'b1; a_a = tab_a[i].a; b_a = tab_a[i].b;
      #1 check("a_in_ready", 64'(in_ready_a), 64'd1);
      @(negedge CLK);
      in_valid_a = 1'b0;
      #1 check("a_q_valid_early", 64'(q_valid_a), 64'd0);
      @(negedge CLK);
      #1;
      check("a_q_valid", 64'(q_valid_a), 64'd1);
      check("a_q", 64'(q_a), 64'(tab_a[i].q));
    end

`ifdef AO_TREE_PIPE_MASK_EN
    // Masked products: both slices all ones, enables decide the result.
    @(negedge CLK);
    rst_c = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      in_valid_c = 1'b1; a_c = 8'hFF; b_c = 8'hFF; en_c = (i == 0) ? 2'b00 : 2'b10;
      @(negedge CLK);
      in_valid_c = 1'b0;
      @(negedge CLK);
      #1;
      check("c_q_valid", 64'(q_valid_c), 64'd1);
      check("c_q", 64'(q_c), (i == 0) ? 64'h0 : 64'hF);
    end
`endif

    // AOI vectors streamed back to back at full throughput.
    for (int i = 0; i < 6; i++) begin
      step_b(1'b1, tab_b[i].a, tab_b[i].b, 4'hF, 1'b1, 1'b0, 1'b1, tab_b[i].q, acc);
      check("b_stream_accept", 64'(acc), 64'd1);
    end
    repeat (4) step_b(1'b0, '0, '0, 4'hF, 1'b1, 1'b0, 1'b0, '0, acc);
    check("b_table_drained", 64'(sb.size()), 64'd0);

    // Ten back-to-back inputs with consumer stalled on cycles 3..6.
    sent = 0;
    pops0 = n_pop;
    saw_block = 1'b0;
    for (int i = 0; i < 40 && (sent < 10 || sb.size() > 0); i++) begin
      step_b(sent < 10, seq_a[sent % 10], seq_b[sent % 10], 4'hF, !(i >= 3 && i <= 6),
             1'b0, 1'b0, '0, acc);
      if (acc) sent++;
    end
    check("b_burst_sent", 64'(sent), 64'd10);
    check("b_burst_popped", 64'(n_pop - pops0), 64'd10);
    check("b_burst_blocked", 64'(saw_block), 64'd1);

    // Full pipe with simultaneous in/out transfer keeps occupancy.
    step_b(1'b1, 32'h1234_5678, 32'hFFFF_0000, 4'hF, 1'b0, 1'b0, 1'b0, '0, acc);
    step_b(1'b1, 32'h0F0F_0F0F, 32'h00FF_00FF, 4'hF, 1'b0, 1'b0, 1'b0, '0, acc);
    check("b_full_occupancy", 64'(sb.size()), 64'd2);
    step_b(1'b1, 32'hAAAA_5555, 32'h5555_AAAA, 4'hF, 1'b1, 1'b0, 1'b0, '0, acc);
    check("b_swap_accept", 64'(acc), 64'd1);
    check("b_swap_occupancy", 64'(sb.size()), 64'd2);

    // Reset with both stages full discards everything, including a same-cycle input.
    step_b(1'b0, '0, '0, 4'hF, 1'b0, 1'b0, 1'b0, '0, acc);
    step_b(1'b1, 32'h1111_1111, 32'h1111_1111, 4'hF, 1'b1, 1'b1, 1'b0, '0, acc);
    step_b(1'b1, 32'h0000_00F0, 32'h0000_00FF, 4'hF, 1'b1, 1'b0, 1'b0, '0, acc);
    check("b_post_rst_q", 64'(q_b), 64'hFF);
    check("b_post_rst_accept", 64'(acc), 64'd1);
    repeat (3) step_b(1'b0, '0, '0, 4'hF, 1'b1, 1'b0, 1'b0, '0, acc);
    check("b_post_rst_drained", 64'(sb.size()), 64'd0);

    // Random stream with random backpressure and enables.
    for (int i = 0; i < 600; i++) begin
      step_b(($urandom % 4) != 0, $urandom, $urandom, 4'($urandom), ($urandom % 3) != 0,
             1'b0, 1'b0, '0, acc);
    end
    for (int i = 0; i < 10 && sb.size() > 0; i++) begin
      step_b(1'b0, '0, '0, 4'hF, 1'b1, 1'b0, 1'b0, '0, acc);
    end
    check("b_random_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
